// File: rtl/image_frame_buf_pkg.sv
// Shared types and defaults for the ping-pong image frame buffer.
package image_frame_buf_pkg;

  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int DEF_PIX_W = 8;

  typedef enum logic {FILL = 1'b0, WAIT = 1'b1} wr_state_e;

  // Coordinates are held wide here and sliced to the image geometry at the top level.
  typedef struct packed {
    logic        empty;
    logic [15:0] xmin;
    logic [15:0] xmax;
    logic [15:0] ymin;
    logic [15:0] ymax;
  } bbox_t;

  localparam bbox_t BBOX_INIT = '{empty: 1'b1, xmin: 16'd0, xmax: 16'd0, ymin: 16'd0, ymax: 16'd0};

  function automatic bbox_t bbox_add(input bbox_t b, input logic [15:0] x, input logic [15:0] y,
                                     input logic nz);
    bbox_t r;
    r = b;
    if (nz) begin
      if (b.empty) begin
        r.empty = 1'b0;
        r.xmin  = x;
        r.xmax  = x;
        r.ymin  = y;
        r.ymax  = y;
      end else begin
        if (x < b.xmin) r.xmin = x;
        if (x > b.xmax) r.xmax = x;
        if (y < b.ymin) r.ymin = y;
        if (y > b.ymax) r.ymax = y;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/image_bank_ram.sv
// One image bank: synchronous write port, synchronous read port, contents never reset.
module image_bank_ram
  import image_frame_buf_pkg::*;
#(
  parameter  int DEPTH = DEF_IMG_W * DEF_IMG_H,
  parameter  int PIX_W = DEF_PIX_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/image_frame_buf.sv
// Double-buffered grayscale frame store: writer fills one bank while the reader owns the other.
// Optional bounding-box tracking of non-zero pixels under IMAGE_FRAME_BUF_BBOX_EN.
module image_frame_buf
  import image_frame_buf_pkg::*;
#(
  parameter  int IMG_W = DEF_IMG_W,
  parameter  int IMG_H = DEF_IMG_H,
  parameter  int PIX_W = DEF_PIX_W,
  localparam int DEPTH = IMG_W * IMG_H,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PIX_W-1:0] wr_pix,
  input  logic             wr_sof,
  input  logic [AW-1:0]    raddr,
  input  logic             rd_en,
  output logic [PIX_W-1:0] rdata,
  output logic             rd_valid,
  output logic             frame_rdy,
  input  logic             frame_release,
  output logic             frame_drop
`ifdef IMAGE_FRAME_BUF_BBOX_EN
  ,
  output logic [$clog2(IMG_W)-1:0] bbox_xmin,
  output logic [$clog2(IMG_W)-1:0] bbox_xmax,
  output logic [$clog2(IMG_H)-1:0] bbox_ymin,
  output logic [$clog2(IMG_H)-1:0] bbox_ymax,
  output logic                     bbox_empty
`endif
);

  wr_state_e      state_q;
  logic           wr_bank_q, wr_ready_q, frame_rdy_q, frame_drop_q;
  logic [AW-1:0]  wr_addr_q, waddr;
  logic           accept, last, swap, rd_in_range;
  logic           rd_valid_q, rd_oor_q, rd_bank_q;
  logic [PIX_W-1:0] ram_q [2];

  assign accept = wr_valid & wr_ready_q;
  assign waddr  = wr_sof ? '0 : wr_addr_q;
  assign last   = accept && (waddr == AW'(DEPTH - 1));
  // A completed bank is handed over immediately if the reader is free, otherwise at release.
  assign swap   = (state_q == FILL) ? (last && (!frame_rdy_q || frame_release)) : frame_release;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wr_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_ready_q   <= 1'b1;
      frame_rdy_q  <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      frame_drop_q <= accept && wr_sof && (wr_addr_q != '0);
      if (accept) wr_addr_q <= last ? '0 : waddr + 1'b1;
      if (swap) begin
        wr_bank_q   <= ~wr_bank_q;
        frame_rdy_q <= 1'b1;
      end else if (frame_release) begin
        frame_rdy_q <= 1'b0;
      end
      case (state_q)
        FILL: if (last && !swap) begin
          state_q    <= WAIT;
          wr_ready_q <= 1'b0;
        end
        WAIT: if (frame_release) begin
          state_q    <= FILL;
          wr_ready_q <= 1'b1;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Compare one bit wider so power-of-two depths do not truncate the bound.
  assign rd_in_range = ({1'b0, raddr} < (AW + 1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_oor_q  <= ~rd_in_range;
        rd_bank_q <= ~wr_bank_q;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    image_bank_ram #(.DEPTH(DEPTH), .PIX_W(PIX_W)) u_ram (
      .clk     (clk),
      .we_i    (accept && (wr_bank_q == 1'(b))),
      .waddr_i (waddr),
      .wdata_i (wr_pix),
      .re_i    (rd_en && rd_in_range),
      .raddr_i (raddr),
      .rdata_o (ram_q[b])
    );
  end

  assign wr_ready   = wr_ready_q;
  assign frame_rdy  = frame_rdy_q;
  assign frame_drop = frame_drop_q;
  assign rd_valid   = rd_valid_q;
  assign rdata      = (rd_valid_q && !rd_oor_q) ? ram_q[rd_bank_q] : '0;

`ifdef IMAGE_FRAME_BUF_BBOX_EN
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0] x_q, px;
  logic [YW-1:0] y_q, py;
  bbox_t         trk_q, box_q, trk_next;

  assign px       = wr_sof ? '0 : x_q;
  assign py       = wr_sof ? '0 : y_q;
  assign trk_next = bbox_add(wr_sof ? BBOX_INIT : trk_q, 16'(px), 16'(py), wr_pix != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      trk_q <= BBOX_INIT;
      box_q <= BBOX_INIT;
    end else begin
      if (accept) begin
        if (last) begin
          x_q <= '0;
          y_q <= '0;
        end else if (px == XW'(IMG_W - 1)) begin
          x_q <= '0;
          y_q <= py + 1'b1;
        end else begin
          x_q <= px + 1'b1;
          y_q <= py;
        end
        trk_q <= trk_next;
      end
      // A pending bank keeps its box in trk_q until the deferred swap.
      if (swap) begin
        box_q <= (state_q == FILL) ? trk_next : trk_q;
        trk_q <= BBOX_INIT;
      end
    end
  end

  assign bbox_xmin  = box_q.xmin[XW-1:0];
  assign bbox_xmax  = box_q.xmax[XW-1:0];
  assign bbox_ymin  = box_q.ymin[YW-1:0];
  assign bbox_ymax  = box_q.ymax[YW-1:0];
  assign bbox_empty = box_q.empty;
`endif

endmodule

// File: tb/tb_image_frame_buf.sv
// Directed and randomized checks of image_frame_buf against a frame-level reference model.
module tb_image_frame_buf;

  logic       clk = 1'b0;
  logic       rst, wr_valid, wr_ready, wr_sof, rd_en, rd_valid, frame_rdy, frame_release, frame_drop;
  logic [7:0] wr_pix, rdata;
  logic [9:0] raddr;
`ifdef IMAGE_FRAME_BUF_BBOX_EN
  logic [4:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic       bbox_empty;
`endif

  always #5 clk = ~clk;

  image_frame_buf dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pix(wr_pix),
    .wr_sof(wr_sof), .raddr(raddr), .rd_en(rd_en), .rdata(rdata), .rd_valid(rd_valid),
    .frame_rdy(frame_rdy), .frame_release(frame_release), .frame_drop(frame_drop)
`ifdef IMAGE_FRAME_BUF_BBOX_EN
    , .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin),
    .bbox_ymax(bbox_ymax), .bbox_empty(bbox_empty)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference: contents of both banks (-1 = never written), plus ownership state.
  int mem [2][784];
  bit m_bank, m_rdy, m_pending;
  int m_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit wv, input int pix, input bit sof, input bit rel,
                     input bit re, input int ra, input bit r = 1'b0);
    int  e_rd, a;
    bit  acc, e_drop;
    rst = r; wr_valid = wv; wr_pix = 8'(pix); wr_sof = sof; frame_release = rel;
    rd_en = re; raddr = 10'(ra);
    e_rd = -1; e_drop = 1'b0;
    if (r) begin
      m_bank = 1'b0; m_addr = 0; m_rdy = 1'b0; m_pending = 1'b0;
    end else begin
      if (re) e_rd = (ra >= 784) ? 0 : mem[!m_bank][ra];
      acc    = wv && !m_pending;
      a      = sof ? 0 : m_addr;
      e_drop = acc && sof && (m_addr != 0);
      if (acc) begin
        mem[m_bank][a] = pix;
        m_addr = (a + 1) % 784;
        if (a == 783) begin
          if (!m_rdy || rel) begin m_bank = !m_bank; m_rdy = 1'b1; end
          else m_pending = 1'b1;
        end else if (rel) m_rdy = 1'b0;
      end else if (m_pending) begin
        if (rel) begin m_bank = !m_bank; m_pending = 1'b0; end
      end else if (rel) m_rdy = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("wr_ready", wr_ready, !m_pending);
    chk("frame_rdy", frame_rdy, m_rdy);
    chk("frame_drop", frame_drop, e_drop);
    chk("rd_valid", rd_valid, re && !r);
    if (r) chk("rdata_rst", rdata, 0);
    else if (re && e_rd >= 0) chk("rdata", rdata, e_rd);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    for (int b = 0; b < 2; b++) for (int i = 0; i < 784; i++) mem[b][i] = -1;
    rst = 1'b1; wr_valid = 1'b0; wr_pix = '0; wr_sof = 1'b0; frame_release = 1'b0;
    rd_en = 1'b0; raddr = '0;
    repeat (3) cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1);

    // Frame 1: ramp pattern, then spot reads.
    for (int i = 0; i < 784; i++) cyc(1'b1, i % 256, i == 0, 1'b0, 1'b0, 0);
    chk("f1_frame_rdy", frame_rdy, 1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 0);   chk("f1_rd0", rdata, 8'h00);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 27);  chk("f1_rd27", rdata, 8'h1B);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 783); chk("f1_rd783", rdata, 8'h0F);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 900); chk("f1_rd_oor", rdata, 0);

    // Frame 2 while reader holds frame 1: writer stalls until release.
    for (int i = 0; i < 784; i++)
      cyc(1'b1, $urandom_range(255), i == 0, 1'b0, 1'b1, $urandom_range(1023));
    chk("f2_stall", wr_ready, 0);
    repeat (3) cyc(1'b1, 7, 1'b0, 1'b0, 1'b1, $urandom_range(783));
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    chk("f2_ready_back", wr_ready, 1);
    chk("f2_rdy_held", frame_rdy, 1);
    repeat (20) cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, $urandom_range(783));

    // Frame 3: last pixel coincides with release, no stall.
    for (int i = 0; i < 784; i++)
      cyc(1'b1, $urandom_range(255), i == 0, i == 783, 1'b1, $urandom_range(783));
    chk("f3_no_stall", wr_ready, 1);
    chk("f3_rdy", frame_rdy, 1);
    repeat (10) cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, $urandom_range(783));

    // Restart mid-frame with wr_sof.
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 100; i++) cyc(1'b1, $urandom_range(255), i == 0, 1'b0, 1'b0, 0);
    cyc(1'b1, $urandom_range(255), 1'b1, 1'b0, 1'b0, 0);
    chk("drop_pulse", frame_drop, 1);
    for (int i = 0; i < 782; i++) cyc(1'b1, $urandom_range(255), 1'b0, 1'b0, 1'b0, 0);
    chk("drop_not_yet", frame_rdy, 0);
    cyc(1'b1, $urandom_range(255), 1'b0, 1'b0, 1'b0, 0);
    chk("drop_complete", frame_rdy, 1);

    // Randomized soak.
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(3) != 0, $urandom_range(255), $urandom_range(300) == 0,
          $urandom_range(40) == 0, $urandom_range(1) == 1, $urandom_range(1023));

    // Reset in the middle of a frame.
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 400; i++) cyc(1'b1, $urandom_range(255), i == 0, 1'b0, 1'b0, 0);
    repeat (3) cyc(1'b1, 0, 1'b0, 1'b1, 1'b1, 3, 1'b1);
    chk("rst_ready", wr_ready, 1);
    chk("rst_frame_rdy", frame_rdy, 0);
    for (int i = 0; i < 784; i++)
      cyc(1'b1, $urandom_range(255), i == 0, 1'b0, 1'b1, $urandom_range(783));
    chk("post_rst_rdy", frame_rdy, 1);
    repeat (5) cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, $urandom_range(1023));

`ifdef IMAGE_FRAME_BUF_BBOX_EN
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 784; i++)
      cyc(1'b1, (i == 3 * 28 + 5 || i == 17 * 28 + 20) ? 9 : 0, i == 0, 1'b0, 1'b0, 0);
    chk("bbox_xmin", bbox_xmin, 5);
    chk("bbox_xmax", bbox_xmax, 20);
    chk("bbox_ymin", bbox_ymin, 3);
    chk("bbox_ymax", bbox_ymax, 17);
    chk("bbox_nonempty", bbox_empty, 0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 784; i++) cyc(1'b1, 0, i == 0, 1'b0, 1'b0, 0);
    chk("bbox_empty", bbox_empty, 1);
    chk("bbox_empty_xmax", bbox_xmax, 0);
    chk("bbox_empty_ymax", bbox_ymax, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_frame_buf.md
Name: image_frame_buf

Overview:
- Parametrised, double-buffered (ping-pong) grayscale image store.
- Successor to the single 28x28 video memory.
- A pixel-stream writer fills one bank while the classifier reads a completed frame from the other.
- Banks swap under a frame_rdy / frame_release handshake, so the writer never overwrites a frame being read.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- PIX_W, 8, bits per pixel
- (derived, localparam) DEPTH = IMG_W*IMG_H; AW = $clog2(DEPTH)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  pixel present on wr_pix
- wr_ready  out  1  writer may accept a pixel this cycle
- wr_pix  in  PIX_W  pixel data, raster order
- wr_sof  in  1  start-of-frame; qualifies the accepted pixel as address 0
- raddr  in  AW  read address in the read bank
- rd_en  in  1  read request
- rdata  out  PIX_W  read data
- rd_valid  out  1  rdata valid
- frame_rdy  out  1  read bank holds an unreleased complete frame
- frame_release  in  1  consumer finished with the read bank
- frame_drop  out  1  one-cycle pulse: partial frame discarded by wr_sof

Behaviour:
- Storage: two banks of DEPTH x PIX_W, inferred sync RAM, no reset on contents. Write bank = wr_bank; read bank = ~wr_bank.
- Pixel accept: a pixel is accepted when wr_valid & wr_ready. It is written to address wr_addr, or to 0 if wr_sof, and wr_addr becomes the written address + 1.
- Writer FSM, FILL state:
  - wr_ready = 1.
  - Accepting the pixel at address DEPTH-1 sets bank_full. wr_addr wraps to 0.
  - If frame_rdy=0 at that edge, or frame_release is asserted that same cycle, swap immediately: toggle wr_bank, frame_rdy=1, stay in FILL.
  - Otherwise go to WAIT.
- Writer FSM, WAIT state:
  - wr_ready = 0. Pending full bank; the consumer still owns the read bank.
  - On frame_release: toggle wr_bank, frame_rdy stays 1, return to FILL. wr_ready=1 from the next cycle.
- Release:
  - frame_release with frame_rdy=1 and no pending bank clears frame_rdy next cycle.
  - frame_release with frame_rdy=0 is ignored.
- wr_sof mid-frame: if wr_addr != 0 when a pixel with wr_sof is accepted, pulse frame_drop for one cycle. The pixel is written to address 0 and wr_addr becomes 1.
- Read path:
  - Latency is 1 cycle. rdata/rd_valid are registered from rd_en and raddr sampled at posedge.
  - raddr >= DEPTH returns 0 with rd_valid=1.
  - Reading while frame_rdy=0 returns stale bank contents; this is legal and not flagged.
  - If a swap and a read occur in the same cycle, the read uses the bank selected before the edge.
- Reset values, asserted at any time including mid-frame:
  - wr_bank=0, wr_addr=0, state FILL
  - wr_ready=1, frame_rdy=0, rd_valid=0, rdata=0, frame_drop=0
  - In-flight frames are abandoned; memory is untouched.

Optional Feature:
- Macro: IMAGE_FRAME_BUF_BBOX_EN.
- When defined:
  - The writer tracks the bounding box of pixels with value != 0 in the frame being filled.
  - Extra outputs: bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, each $clog2(IMG_W or IMG_H) bits, and bbox_empty.
  - The bounding box is latched for the read bank at swap, together with frame_rdy.
  - An all-zero frame gives bbox_empty=1 and all coordinates 0.
  - Trackers reset on wr_sof and on rst.
- When undefined: the ports and logic are absent.

Decomposition:
- Package image_frame_buf_pkg:
  - writer state enum {FILL, WAIT}
  - default IMG_W/IMG_H/PIX_W constants
  - bbox struct type
- One natural sub-module: image_bank_ram, a single-port-write / single-port-read sync RAM (DEPTH, PIX_W), instantiated twice.

Test Plan:
- Reset, then stream 784 pixels of value (addr mod 256) with wr_sof on the first pixel:
  - frame_rdy rises on the cycle after the last accept.
  - Reading raddr=0, 27, 783 gives 0x00, 0x1B, 0x0F on the following cycle with rd_valid=1.
- With frame_rdy=1 and no release, stream a second full frame:
  - wr_ready drops after the 784th accept.
  - Asserting frame_release restores wr_ready one cycle later; frame_rdy stays 1 and the second frame's data is now readable.
- Accept the last pixel in the same cycle as frame_release:
  - Banks swap with no WAIT state; wr_ready never drops.
- Accept 100 pixels, then a pixel with wr_sof:
  - frame_drop pulses once.
  - frame_rdy asserts only after a further 783 accepts.
- Assert rst at pixel 400 of a frame:
  - All outputs return to their reset values while rst is high.
  - After release, a full new frame sets frame_rdy normally.
- BBOX_EN: frame that is zero except pixels at (x=5,y=3) and (x=20,y=17):
  - bbox = {5,20,3,17}, bbox_empty=0.
  - An all-zero frame gives bbox_empty=1.
